// File: rtl/bsg_fifo_1r1w_large_wide.sv
// bsg_fifo_1r1w_large_wide
//   Deep, wide 1R1W FIFO built around one single-port (1RW) synchronous RAM.
//   Incoming words collect in a small flop "buncher". Groups of ways_p words are
//   written to the RAM as one row. Rows read back from the RAM land in a small
//   flop "staging" FIFO that presents the oldest word. Because every RAM access
//   moves ways_p words, one RAM port can sustain one enqueue and one dequeue
//   per cycle.
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   data_i/v_i   write data / write valid (enqueue on v_i & ready_and_o)
//   ready_and_o  buncher has a free slot
//   v_o/data_o   staging non-empty / oldest word
//   yumi_i       dequeue (only legal while v_o=1)
//   count_o      total words held anywhere in the FIFO
module bsg_fifo_1r1w_large_wide #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 16,
    parameter int unsigned ways_p  = 2
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [width_p-1:0]                      data_i,
    input  logic                                    v_i,
    output logic                                    ready_and_o,
    output logic                                    v_o,
    output logic [width_p-1:0]                      data_o,
    input  logic                                    yumi_i,
    output logic [$clog2(els_p+4*ways_p+1)-1:0]     count_o
);

    localparam int unsigned Rows    = els_p / ways_p;
    localparam int unsigned FifoEls = 2 * ways_p;
    localparam int unsigned PtrW    = $clog2(FifoEls);
    localparam int unsigned CntFW   = PtrW + 1;
    localparam int unsigned RowPtrW = $clog2(Rows);
    localparam int unsigned RowsW   = $clog2(Rows + 1);
    localparam int unsigned CntW    = $clog2(els_p + 4 * ways_p + 1);
    localparam int unsigned RowW    = ways_p * width_p;

    // Storage (not reset; never read before written)
    logic [width_p-1:0] bun_mem_q [FifoEls];
    logic [width_p-1:0] stg_mem_q [FifoEls];
    logic [RowW-1:0]    ram_q     [Rows];
    logic [RowW-1:0]    ram_rdata_q;

    // Control state
    logic [PtrW-1:0]    bun_rd_q, bun_rd_d, bun_wr_q, bun_wr_d;
    logic [CntFW-1:0]   bun_cnt_q, bun_cnt_d;
    logic [PtrW-1:0]    stg_rd_q, stg_rd_d, stg_wr_q, stg_wr_d;
    logic [CntFW-1:0]   stg_cnt_q, stg_cnt_d;
    logic [RowPtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [RowsW-1:0]   rows_q, rows_d;
    logic               restore_q, restore_d;
    logic [CntW-1:0]    count_q, count_d;

    logic             enq, deq, ram_empty, ram_full;
    logic             do_restore, do_spill, do_drain;
    logic [CntFW-1:0] stg_free;
    logic [PtrW-1:0]  stg_push_n;
    logic [RowW-1:0]  spill_row;

    assign ready_and_o = ~reset_i & (bun_cnt_q != CntFW'(FifoEls));
    assign v_o         = (stg_cnt_q != '0);
    assign data_o      = stg_mem_q[stg_rd_q];
    assign count_o     = count_q;

    assign enq = v_i & ready_and_o;
    assign deq = yumi_i & v_o;

    assign ram_empty = (rows_q == '0);
    assign ram_full  = (rows_q == RowsW'(Rows));

    // Slots already promised to an in-flight restore count as occupied; a pop in
    // the same cycle is not credited, so staging can never overflow.
    assign stg_free = CntFW'(FifoEls) - stg_cnt_q - (restore_q ? CntFW'(ways_p) : '0);

    assign do_restore = ~ram_empty & ~restore_q & (stg_free >= CntFW'(ways_p));
    // Buncher may bypass the RAM only when nothing older is in RAM or in flight.
    assign do_drain   = ram_empty & ~restore_q & (stg_cnt_q != CntFW'(FifoEls)) &
                        (bun_cnt_q != '0);
    assign do_spill   = ~do_restore & ~do_drain & ~ram_full & (bun_cnt_q >= CntFW'(ways_p));

    assign stg_push_n = restore_q ? PtrW'(ways_p) : PtrW'(do_drain);

    always_comb begin
        spill_row = '0;
        for (int i = 0; i < ways_p; i++) begin
            spill_row[i*width_p +: width_p] = bun_mem_q[bun_rd_q + PtrW'(i)];
        end
    end

    always_comb begin
        bun_wr_d  = bun_wr_q + PtrW'(enq);
        bun_rd_d  = bun_rd_q + (do_spill ? PtrW'(ways_p) : PtrW'(do_drain));
        bun_cnt_d = bun_cnt_q + CntFW'(enq) - (do_spill ? CntFW'(ways_p) : '0) -
                    CntFW'(do_drain);

        stg_wr_d  = stg_wr_q + stg_push_n;
        stg_rd_d  = stg_rd_q + PtrW'(deq);
        stg_cnt_d = stg_cnt_q + CntFW'(stg_push_n) - CntFW'(deq);

        head_d    = head_q;
        tail_d    = tail_q;
        rows_d    = rows_q;
        if (do_restore) begin
            head_d = (head_q == RowPtrW'(Rows - 1)) ? '0 : head_q + RowPtrW'(1);
            rows_d = rows_q - RowsW'(1);
        end else if (do_spill) begin
            tail_d = (tail_q == RowPtrW'(Rows - 1)) ? '0 : tail_q + RowPtrW'(1);
            rows_d = rows_q + RowsW'(1);
        end
        restore_d = do_restore;

        count_d   = count_q + CntW'(enq) - CntW'(deq);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bun_rd_q  <= '0;
            bun_wr_q  <= '0;
            bun_cnt_q <= '0;
            stg_rd_q  <= '0;
            stg_wr_q  <= '0;
            stg_cnt_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rows_q    <= '0;
            restore_q <= 1'b0;
            count_q   <= '0;
        end else begin
            bun_rd_q  <= bun_rd_d;
            bun_wr_q  <= bun_wr_d;
            bun_cnt_q <= bun_cnt_d;
            stg_rd_q  <= stg_rd_d;
            stg_wr_q  <= stg_wr_d;
            stg_cnt_q <= stg_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rows_q    <= rows_d;
            restore_q <= restore_d;
            count_q   <= count_d;
        end
    end

    // Data arrays and the single-port RAM: at most one RAM access per cycle.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            bun_mem_q[bun_wr_q] <= data_i;
        end
        if (restore_q) begin
            // Low word of the row is the oldest.
            for (int i = 0; i < ways_p; i++) begin
                stg_mem_q[stg_wr_q + PtrW'(i)] <= ram_rdata_q[i*width_p +: width_p];
            end
        end else if (do_drain) begin
            stg_mem_q[stg_wr_q] <= bun_mem_q[bun_rd_q];
        end
        if (do_spill) begin
            ram_q[tail_q] <= spill_row;
        end else if (do_restore) begin
            ram_rdata_q <= ram_q[head_q];
        end
    end

    a_params:     assert property (@(posedge clk_i) (els_p % ways_p) == 0);
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
    a_no_v_reset: assert property (@(posedge clk_i) reset_i |-> !v_i);
    a_count_max:  assert property (@(posedge clk_i) disable iff (reset_i)
                                   count_q <= CntW'(els_p + 4 * ways_p));

endmodule
